// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and constants for the PC generator.
//   pc_state_e            - BOOT / RUN / HALT state encoding
//   DEFAULT_RESET_VECTOR  - default first fetch address after reset
//   pc_misaligned_chk     - alignment test on the low PC bits
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h8000_0000;

  // Only INST_BYTES of 2 or 4 are legal, so the two low bits are enough.
  function automatic logic pc_misaligned_chk(input logic [1:0] lo, input int inst_bytes);
    return (inst_bytes == 2) ? lo[0] : (|lo);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: request/response bundle between the PC generator and its
// neighbours (trap unit, execute, branch predictor, fetch, debug).
//   master : PC generator side (drives pc, pc_valid, pc_misaligned, halted,
//            redirect_cnt and the debug state)
//   slave  : environment side (drives the redirect, prediction, fetch_ready
//            and halt requests)
//
// Handshake: pc is transferred to fetch on a rising edge where
// pc_valid && fetch_ready are both high. pc_valid never depends on
// fetch_ready, and while pc_valid is high with fetch_ready low the offered pc
// stays stable unless a trap or execute redirect replaces it.
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             trap_valid;
  logic [XLEN-1:0]  trap_pc;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             pred_valid;
  logic [XLEN-1:0]  pred_pc;
  logic             fetch_ready;
  logic             halt_req;
  logic [XLEN-1:0]  pc;
  logic             pc_valid;
  logic             pc_misaligned;
  logic             halted;
  logic [CNT_W-1:0] redirect_cnt;
  pc_state_e        state;

  modport master (
    input  trap_valid, trap_pc, redirect_valid, redirect_pc,
           pred_valid, pred_pc, fetch_ready, halt_req,
    output pc, pc_valid, pc_misaligned, halted, redirect_cnt, state
  );

  modport slave (
    output trap_valid, trap_pc, redirect_valid, redirect_pc,
           pred_valid, pred_pc, fetch_ready, halt_req,
    input  pc, pc_valid, pc_misaligned, halted, redirect_cnt, state
  );

endinterface

// File: rtl/pc_gen_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones.
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the count
//   inc   - count one event this cycle
//   count - current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - pc_gen_if.master: redirect/prediction/halt requests in; pc,
//          pc_valid, pc_misaligned, halted, redirect_cnt and debug state out
// After reset the block idles BOOT_DELAY cycles, then offers RESET_VECTOR and
// walks forward by INST_BYTES on every accepted transfer. Traps and execute
// redirects replace the pc whether or not fetch took it; a debug halt parks
// the block until a trap resumes it.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int              INST_BYTES   = 4,
  parameter int              BOOT_DELAY   = 2,
  parameter int              CNT_W        = 32
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.master bus
);

  pc_state_e       state_q;
  logic [3:0]      boot_cnt_q;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            pc_misaligned_q;
  logic            halted_q;

  logic [XLEN-1:0] next_pc;
  logic            redir_accept;
  logic            transfer;
  logic [CNT_W-1:0] cnt;

  assign transfer = pc_valid_q && bus.fetch_ready;

  // Single priority mux for the next pc. In RUN the order is
  // trap > redirect > halt (hold) > prediction > sequential > hold; the last
  // two only apply when fetch actually took the current pc. In HALT only a
  // trap can move the pc.
  always_comb begin
    next_pc      = pc_q;
    redir_accept = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.trap_valid) begin
          next_pc      = bus.trap_pc;
          redir_accept = 1'b1;
        end else if (bus.redirect_valid) begin
          next_pc      = bus.redirect_pc;
          redir_accept = 1'b1;
        end else if (bus.halt_req) begin
          next_pc = pc_q;
        end else if (transfer) begin
          next_pc = bus.pred_valid ? bus.pred_pc : (pc_q + XLEN'(INST_BYTES));
        end else begin
          next_pc = pc_q;
        end
      end
      HALT: begin
        if (bus.trap_valid) begin
          next_pc      = bus.trap_pc;
          redir_accept = 1'b1;
        end
      end
      default: next_pc = RESET_VECTOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= BOOT;
      boot_cnt_q      <= 4'(BOOT_DELAY);
      pc_q            <= RESET_VECTOR;
      pc_valid_q      <= 1'b0;
      pc_misaligned_q <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      pc_q            <= next_pc;
      pc_misaligned_q <= pc_misaligned_chk(next_pc[1:0], INST_BYTES);
      case (state_q)
        BOOT: begin
          if (boot_cnt_q != 4'd0) begin
            boot_cnt_q <= boot_cnt_q - 4'd1;
          end
          // The counter reaches zero on the same edge RUN begins, so the
          // first valid pc appears exactly BOOT_DELAY edges after reset.
          if (boot_cnt_q <= 4'd1) begin
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
          end
        end
        RUN: begin
          // A trap or redirect in the same cycle beats halt; halt_req is
          // simply looked at again next cycle.
          if (!bus.trap_valid && !bus.redirect_valid && bus.halt_req) begin
            state_q    <= HALT;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b1;
          end
        end
        HALT: begin
          if (bus.trap_valid) begin
            state_q    <= RUN;
            pc_valid_q <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        default: begin
          state_q    <= BOOT;
          boot_cnt_q <= 4'(BOOT_DELAY);
          pc_valid_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redir_accept),
    .count (cnt)
  );

  assign bus.pc            = pc_q;
  assign bus.pc_valid      = pc_valid_q;
  assign bus.pc_misaligned = pc_misaligned_q;
  assign bus.halted        = halted_q;
  assign bus.redirect_cnt  = cnt;
  assign bus.state         = state_q;

endmodule
